pipe_chain_ctrl: RTL and testbench

- Parametrised pipeline-register chain with integrated hazard control for the rv32 core. Successor to the fixed per-stage id_ex/ex_mem/mem_wb registers and the separate hazard logic.
- Carries NSTAGES register stages, starting at EX entry, of payload plus valid/rd/regwrite/memread tags.
- Detects load-use hazards and inserts bubbles. Applies branch flush and global freeze.
- Generates EX-operand forwarding selects from all downstream stages. Counts stall cycles.

---
 rtl/pipe_chain_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_chain_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_chain_ctrl.sv
// pipe_chain_ctrl: parametrised EX..WB pipeline-register chain with load-use
// bubble insertion, branch flush, global freeze, EX-operand forwarding selects
// and a saturating stall-cycle counter.
module pipe_chain_ctrl #(
  parameter int NSTAGES = 4,
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int SELW    = $clog2(NSTAGES),
  parameter int CW      = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_payload,
  input  logic [RW-1:0]         in_rs1,
  input  logic [RW-1:0]         in_rs2,
  input  logic [RW-1:0]         in_rd,
  input  logic                  in_regwrite,
  input  logic                  in_memread,
  input  logic                  flush,
  input  logic                  ext_stall,
  output logic [NSTAGES-1:0]    stage_valid,
  output logic [NSTAGES*DW-1:0] stage_payload,
  output logic [NSTAGES*RW-1:0] stage_rd,
  output logic [NSTAGES-1:0]    stage_regwrite,
  output logic [SELW-1:0]       fwd_sel1,
  output logic [SELW-1:0]       fwd_sel2,
  output logic                  load_use_stall,
  output logic [CW-1:0]         stall_cnt
);

  // Per-stage state; a bubble is all-zero in every field.
  logic          vld [NSTAGES];
  logic          rwr [NSTAGES];
  logic          mrd [NSTAGES];
  logic [RW-1:0] rdt [NSTAGES];
  logic [DW-1:0] pld [NSTAGES];
  logic [RW-1:0] rs1_0;
  logic [RW-1:0] rs2_0;

  logic hazard;
  logic take_input;

  // Load-use detection against the instruction currently in decode; x0 never hazards.
  always_comb begin
    hazard = vld[0] && mrd[0] && (rdt[0] != {RW{1'b0}}) && in_valid &&
             ((rdt[0] == in_rs1) || (rdt[0] == in_rs2));
  end

  // Handshake: freeze blocks everything, flush swallows the input, hazard holds it back.
  always_comb begin
    if (!resetn || ext_stall) begin
      in_ready       = 1'b0;
      load_use_stall = 1'b0;
    end else if (flush) begin
      in_ready       = 1'b1;
      load_use_stall = 1'b0;
    end else begin
      in_ready       = !hazard;
      load_use_stall = hazard;
    end
    take_input = in_ready && in_valid && !flush;
  end

  // Forwarding selects: scan oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_sel1 = {SELW{1'b0}};
    fwd_sel2 = {SELW{1'b0}};
    for (int k = NSTAGES - 1; k >= 1; k--) begin
      if (vld[0] && vld[k] && rwr[k] && (rdt[k] != {RW{1'b0}})) begin
        if (rdt[k] == rs1_0) begin
          fwd_sel1 = SELW'(k);
        end else begin
          fwd_sel1 = fwd_sel1;
        end
        if (rdt[k] == rs2_0) begin
          fwd_sel2 = SELW'(k);
        end else begin
          fwd_sel2 = fwd_sel2;
        end
      end else begin
        fwd_sel1 = fwd_sel1;
        fwd_sel2 = fwd_sel2;
      end
    end
  end

  // Pack per-stage registers onto the flat output buses.
  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      stage_valid[k]              = vld[k];
      stage_regwrite[k]           = rwr[k];
      stage_payload[k*DW +: DW]   = pld[k];
      stage_rd[k*RW +: RW]        = rdt[k];
    end
  end

  // Chain advance: hold on freeze, otherwise shift and load stage 0 with input or bubble.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NSTAGES; k++) begin
        vld[k] <= 1'b0;
        rwr[k] <= 1'b0;
        mrd[k] <= 1'b0;
        rdt[k] <= {RW{1'b0}};
        pld[k] <= {DW{1'b0}};
      end
      rs1_0 <= {RW{1'b0}};
      rs2_0 <= {RW{1'b0}};
    end else if (ext_stall) begin
      for (int k = 0; k < NSTAGES; k++) begin
        vld[k] <= vld[k];
        rwr[k] <= rwr[k];
        mrd[k] <= mrd[k];
        rdt[k] <= rdt[k];
        pld[k] <= pld[k];
      end
      rs1_0 <= rs1_0;
      rs2_0 <= rs2_0;
    end else begin
      for (int k = 1; k < NSTAGES; k++) begin
        vld[k] <= vld[k-1];
        rwr[k] <= rwr[k-1];
        mrd[k] <= mrd[k-1];
        rdt[k] <= rdt[k-1];
        pld[k] <= pld[k-1];
      end
      if (take_input) begin
        vld[0] <= 1'b1;
        rwr[0] <= in_regwrite;
        mrd[0] <= in_memread;
        rdt[0] <= in_rd;
        pld[0] <= in_payload;
        rs1_0  <= in_rs1;
        rs2_0  <= in_rs2;
      end else begin
        vld[0] <= 1'b0;
        rwr[0] <= 1'b0;
        mrd[0] <= 1'b0;
        rdt[0] <= {RW{1'b0}};
        pld[0] <= {DW{1'b0}};
        rs1_0  <= {RW{1'b0}};
        rs2_0  <= {RW{1'b0}};
      end
    end
  end

  // Saturating count of cycles where decode offers an instruction that is refused.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= {CW{1'b0}};
    end else if (in_valid && !in_ready && (stall_cnt != {CW{1'b1}})) begin
      stall_cnt <= stall_cnt + CW'(1'b1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_chain_ctrl.sv
// Directed self-checking bench for pipe_chain_ctrl (NSTAGES=4, CW=3 so the
// stall counter saturation at 7 is reachable).
module tb_pipe_chain_ctrl;

  localparam int NSTAGES = 4;
  localparam int DW      = 32;
  localparam int RW      = 5;
  localparam int SELW    = 2;
  localparam int CW      = 3;

  logic                  clk;
  logic                  resetn;
  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_payload;
  logic [RW-1:0]         in_rs1;
  logic [RW-1:0]         in_rs2;
  logic [RW-1:0]         in_rd;
  logic                  in_regwrite;
  logic                  in_memread;
  logic                  flush;
  logic                  ext_stall;
  logic [NSTAGES-1:0]    stage_valid;
  logic [NSTAGES*DW-1:0] stage_payload;
  logic [NSTAGES*RW-1:0] stage_rd;
  logic [NSTAGES-1:0]    stage_regwrite;
  logic [SELW-1:0]       fwd_sel1;
  logic [SELW-1:0]       fwd_sel2;
  logic                  load_use_stall;
  logic [CW-1:0]         stall_cnt;

  int checks = 0;
  int errors = 0;
  logic seen55;

  pipe_chain_ctrl #(
    .NSTAGES(NSTAGES), .DW(DW), .RW(RW), .SELW(SELW), .CW(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memread(in_memread),
    .flush(flush), .ext_stall(ext_stall),
    .stage_valid(stage_valid), .stage_payload(stage_payload),
    .stage_rd(stage_rd), .stage_regwrite(stage_regwrite),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .load_use_stall(load_use_stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pl, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    in_valid    = v;
    in_payload  = pl;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = rd;
    in_regwrite = rw;
    in_memread  = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    resetn = 1'b0;
    flush = 1'b0;
    ext_stall = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", stage_valid, 4'b0000);
    check_eq("rst_cnt", stall_cnt, 3'd0);
    check_eq("rst_ready", in_ready, 1'b0);
    check_eq("rst_fwd", {fwd_sel1, fwd_sel2, load_use_stall}, 5'd0);
    resetn = 1'b1;

    // Straight flow A..D, D reads x2 (stage 2) and x3 (stage 1)
    drive(1'b1, 32'hA, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    #1 check_eq("flow_ready", in_ready, 1'b1);
    tick();
    drive(1'b1, 32'hB, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hC, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hD, 5'd2, 5'd3, 5'd4, 1'b1, 1'b0); tick();
    check_eq("flow_valid", stage_valid, 4'b1111);
    check_eq("flow_pl3", stage_payload[3*DW +: DW], 32'hA);
    check_eq("flow_pl0", stage_payload[0 +: DW], 32'hD);
    check_eq("flow_rd", stage_rd, {5'd1, 5'd2, 5'd3, 5'd4});
    check_eq("flow_fwd1", fwd_sel1, 2'd2);
    check_eq("flow_fwd2", fwd_sel2, 2'd1);
    idle(4);
    check_eq("drain_valid", stage_valid, 4'b0000);

    // Load-use on rs2
    drive(1'b1, 32'h100, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h200, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0);
    #1;
    check_eq("lu_stall", load_use_stall, 1'b1);
    check_eq("lu_ready", in_ready, 1'b0);
    tick();
    check_eq("lu_bubble", stage_valid, 4'b0010);
    check_eq("lu_cnt", stall_cnt, 3'd1);
    check_eq("lu_resolved", {load_use_stall, in_ready}, 2'b01);
    tick();
    check_eq("lu_valid2", stage_valid, 4'b0101);
    check_eq("lu_pl0", stage_payload[0 +: DW], 32'h200);
    check_eq("lu_fwd2", fwd_sel2, 2'd2);
    check_eq("lu_fwd1", fwd_sel1, 2'd0);
    idle(4);

    // Forward priority: two producers of x7, youngest wins
    drive(1'b1, 32'h1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h2, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h3, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    check_eq("prio_fwd1", fwd_sel1, 2'd1);
    // x0 writer in stage 1, reader of x0 in stage 0
    drive(1'b1, 32'h4, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    check_eq("x0_fwd1", fwd_sel1, 2'd0);
    idle(4);
    // Load into x0 must not hazard
    drive(1'b1, 32'h6, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h7, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    #1 check_eq("x0_nohaz", {load_use_stall, in_ready}, 2'b01);
    tick();
    idle(4);

    // Flush discards the decoding instruction
    drive(1'b1, 32'h55, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    #1 check_eq("fl_ready", in_ready, 1'b1);
    tick();
    flush = 1'b0;
    check_eq("fl_valid0", stage_valid[0], 1'b0);
    check_eq("fl_cnt", stall_cnt, 3'd1);
    seen55 = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (stage_valid[k] && stage_payload[k*DW +: DW] == 32'h55) seen55 = 1'b1;
      end
      tick();
    end
    check_eq("fl_never", seen55, 1'b0);

    // Freeze with flush and input pending; counter saturates at 7
    drive(1'b1, 32'h77, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h99, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
    flush = 1'b1;
    ext_stall = 1'b1;
    #1 check_eq("frz_ready", {in_ready, load_use_stall}, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    check_eq("frz_valid", stage_valid, 4'b0001);
    check_eq("frz_pl0", stage_payload[0 +: DW], 32'h77);
    check_eq("frz_cnt", stall_cnt, 3'd6);
    for (int i = 0; i < 3; i++) tick();
    check_eq("frz_sat", stall_cnt, 3'd7);
    ext_stall = 1'b0;
    flush = 1'b0;
    idle(4);

    // Reset mid-stream with three valid stages
    drive(1'b1, 32'h11, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h12, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h13, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();
    check_eq("mid_valid", stage_valid, 4'b0111);
    drive(1'b1, 32'hF0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_eq("mid_rst_valid", stage_valid, 4'b0000);
    check_eq("mid_rst_cnt", stall_cnt, 3'd0);
    check_eq("mid_rst_ready", in_ready, 1'b0);
    tick();
    check_eq("mid_rst_hold", stage_valid, 4'b0000);
    @(negedge clk);
    resetn = 1'b1;
    #1 check_eq("rel_ready", in_ready, 1'b1);
    tick();
    check_eq("rel_valid", stage_valid, 4'b0001);
    check_eq("rel_pl0", stage_payload[0 +: DW], 32'hF0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
